// File: rtl/input_unit_pkg.sv
// Shared types and constants for the calculator input unit: FSM state
// encoding, signed-range limits and the BCD digit type.
package input_unit_pkg;

    // Entry state machine
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // One decimal digit as it arrives from the switches
    typedef logic [3:0] bcd_digit_t;

    // Largest magnitudes representable in 8-bit two's complement
    localparam int POS_LIMIT  = 127;
    localparam int NEG_LIMIT  = 128;

    // Digits accepted per entry
    localparam int MAX_DIGITS = 3;

    // True when a switch value is a legal decimal digit
    function automatic logic is_decimal(input bcd_digit_t d);
        return (d <= bcd_digit_t'(9));
    endfunction

endpackage

// File: rtl/input_unit_if.sv
// Key/operand bundle between the operator panel and the input unit.
// The master side drives the raw keys and switch digit; the slave side
// (the input unit) returns the committed operand and the entry echo.
interface input_unit_if;
    import input_unit_pkg::*;

    bcd_digit_t digit_sw;
    logic       digit_key;
    logic       sign_key;
    logic       enter_key;
    logic       clear_key;

    logic [7:0] value;
    logic       value_valid;
    logic       range_err;
    logic       entry_neg;
    logic [1:0] entry_hun;
    bcd_digit_t entry_tens;
    bcd_digit_t entry_ones;

    modport master (
        output digit_sw, digit_key, sign_key, enter_key, clear_key,
        input  value, value_valid, range_err, entry_neg,
        input  entry_hun, entry_tens, entry_ones
    );

    modport slave (
        input  digit_sw, digit_key, sign_key, enter_key, clear_key,
        output value, value_valid, range_err, entry_neg,
        output entry_hun, entry_tens, entry_ones
    );
endinterface

// File: rtl/input_unit_key_conditioner.sv
// Conditions one raw pushbutton into a single-cycle press pulse:
// synchronizer -> optional debouncer -> registered rising-edge detector.
// Optional debounce is enabled by defining INPUT_UNIT_DEBOUNCE_EN.
// With SYNC_STAGES=2 and no debounce, a rise sampled at edge N yields a
// pulse that the consumer acts on at edge N+3.
module key_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic press_o
);

    // Reject configurations the structure cannot build
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("key_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level;
    logic                   prev_q;
    logic                   press_q;

    // Synchronizer chain for the asynchronous button level
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef INPUT_UNIT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             db_q;

    // Saturating stability counter: adopt the new level after it has held
    // for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (sync_out == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            db_q  <= sync_out;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level = db_q;
`else
    assign level = sync_out;
`endif

    // Registered rising-edge detector producing a one-cycle press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= level;
            press_q <= level & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/input_unit.sv
// Calculator input unit: turns digit/sign/enter/clear keypresses into an
// 8-bit two's-complement operand with a one-cycle valid strobe, and echoes
// the entry (sign + BCD digits) for the display path.
// Optional key debounce is enabled by defining INPUT_UNIT_DEBOUNCE_EN.
module input_unit
    import input_unit_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         reset,
    input_unit_if.slave  bus
);

    logic digit_p, sign_p, enter_p, clear_p;

    key_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_digit (.clk(clk), .reset(reset), .key_i(bus.digit_key), .press_o(digit_p));
    key_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_sign  (.clk(clk), .reset(reset), .key_i(bus.sign_key),  .press_o(sign_p));
    key_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_enter (.clk(clk), .reset(reset), .key_i(bus.enter_key), .press_o(enter_p));
    key_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_clear (.clk(clk), .reset(reset), .key_i(bus.clear_key), .press_o(clear_p));

    state_t     state_q,  state_d;
    logic [9:0] mag_q,    mag_d;     // binary magnitude of the entry, 0..999
    logic [1:0] hun_q,    hun_d;
    bcd_digit_t tens_q,   tens_d;
    bcd_digit_t ones_q,   ones_d;
    logic [1:0] ndig_q,   ndig_d;    // digits held in the current entry
    logic       neg_q,    neg_d;
    logic [7:0] value_q,  value_d;
    logic       valid_q,  valid_d;
    logic       err_q,    err_d;

    bcd_digit_t digit;
    logic       digit_ok;
    logic [9:0] limit;

    assign digit    = bus.digit_sw;
    assign digit_ok = is_decimal(digit);
    assign limit    = neg_q ? 10'(NEG_LIMIT) : 10'(POS_LIMIT);

    // Next-state and datapath decode; only the highest-priority press acts
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        hun_d   = hun_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        ndig_d  = ndig_q;
        neg_d   = neg_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = err_q;

        if (clear_p) begin
            mag_d   = '0;
            hun_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
            ndig_d  = '0;
            neg_d   = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
        end else if (enter_p) begin
            if (state_q == ENTRY) begin
                if (mag_q <= limit) begin
                    // Negation mod 256 maps -0 to 0x00 and -128 to 0x80
                    value_d = neg_q ? 8'(~mag_q[7:0] + 8'd1) : mag_q[7:0];
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end
        end else if (sign_p) begin
            if (state_q == IDLE || state_q == ENTRY) begin
                neg_d = ~neg_q;
            end
        end else if (digit_p && digit_ok) begin
            unique case (state_q)
                IDLE, DONE: begin
                    // Start a fresh entry; a new entry after a commit is positive
                    mag_d   = {6'd0, digit};
                    hun_d   = '0;
                    tens_d  = '0;
                    ones_d  = digit;
                    ndig_d  = 2'd1;
                    if (state_q == DONE) neg_d = 1'b0;
                    state_d = ENTRY;
                end
                ENTRY: begin
                    if (ndig_q < 2'(MAX_DIGITS)) begin
                        mag_d  = (mag_q << 3) + (mag_q << 1) + {6'd0, digit};
                        // Hundreds echo is two bits wide: it carries the low
                        // bits of the shifted-up tens digit
                        hun_d  = tens_q[1:0];
                        tens_d = ones_q;
                        ones_d = digit;
                        ndig_d = ndig_q + 2'd1;
                    end
                end
                default: ;  // ERROR waits for clear
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            hun_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            ndig_q  <= '0;
            neg_q   <= 1'b0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            hun_q   <= hun_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            ndig_q  <= ndig_d;
            neg_q   <= neg_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.range_err   = err_q;
    assign bus.entry_neg   = neg_q;
    assign bus.entry_hun   = hun_q;
    assign bus.entry_tens  = tens_q;
    assign bus.entry_ones  = ones_q;

endmodule
